ad9783_spi_responder: RTL and testbench
=======================================

Name: ad9783_spi_responder

Overview:
- SPI responder (target) for the AD9783 serial control port; the opposite end of the AD9783 driver's SPI initiator.
- Decodes the instruction byte, performs 1–4 byte writes and reads against a 32 x 8 register file, and drives readback on SDO.
- Used as the bench/loopback model for the DAC_test firmware. Also usable as an on-FPGA register shadow.
- Oversamples SCS/SCK/SDI in the clk_in domain; clk_in must be at least 8x the SCK rate.

Parameters:
SYNC_STAGES, 2, synchronizer flops on spi_scs_in/spi_sck_in/spi_sdi_in (min 2)
VERSION, 8'h0A, read-only value returned at address 0x1F
REG_WRITE_MASK, 32'h7FFF_FFFF, bit i = 1 means address i is writable

Ports:
clk_in  in  1  system clock (100 MHz in DAC_test)
rst_n_in  in  1  reset, synchronous, active-low
spi_scs_in  in  1  chip select, active-low, from initiator
spi_sck_in  in  1  serial clock, idle low
spi_sdi_in  in  1  serial data from initiator (initiator's SDO)
spi_sdo_out  out  1  serial readback data (initiator's SDI)
spi_sdo_oe_out  out  1  high while readback bits are driven
wr_strobe_out  out  1  one-cycle pulse per committed write byte
wr_addr_out  out  5  address of the committed byte
wr_data_out  out  8  data of the committed byte
reg_addr_in  in  5  local asynchronous-read port address
reg_data_out  out  8  register file content at reg_addr_in (combinational)
busy_out  out  1  high while a transaction is in progress (state != IDLE)

Behaviour:
- Reset (rst_n_in=0 at a clk_in edge): all registers become 0x00, except 0x1F, which reads VERSION. FSM goes to IDLE. spi_sdo_out=0, spi_sdo_oe_out=0, wr_strobe_out=0, wr_addr_out=0, wr_data_out=0, busy_out=0. Synchronizers are cleared to the SCS=1, SCK=0, SDI=0 idle state.
- Edge detection: edges are detected on the last synchronizer stage against a delayed copy. Events are SCK rise, SCK fall, SCS fall and SCS rise. An edge at the pins is acted on SYNC_STAGES+1 cycles later.
- Frame:
  - SDI is sampled on SCK rise, MSB first.
  - Instruction byte: bit7 = R/nW (1 = read); bits6:5 = N, giving a byte count of N+1; bits4:0 = start address.
  - Address decrements after each data byte, wrapping from 0x00 to 0x1F.
- FSM states:
  - IDLE: on SCS fall, clear the bit counter and go to INSTR.
  - INSTR: after 8 SCK rises, latch R/nW, count and address; go to WDATA or RDATA.
  - WDATA: after every 8 SCK rises, the byte is committed on the next cycle. If REG_WRITE_MASK[addr] is set, the register is updated; wr_strobe_out pulses and wr_addr_out/wr_data_out carry the byte regardless of the mask. The counter then decrements; at 0, go to DONE.
  - RDATA: the addressed register is loaded into the SDO shift register in the cycle the instruction completes. The MSB is driven immediately with spi_sdo_oe_out=1, and the register shifts on each SCK fall. After 8 SCK rises, the next address is loaded. After the last byte, go to DONE; oe stays high until SCS rise.
  - DONE: further SCK edges are ignored and do not write. On SCS rise, go to IDLE.
- SCS rise in any state: return to IDLE next cycle with spi_sdo_oe_out=0. A partial byte is discarded; bytes already committed are kept.
- SCS fall while not IDLE cannot occur, because SCS rise always precedes it; no special handling is required.
- Write and local read of the same address in the same cycle: reg_data_out shows the old value until the write cycle completes.
- rst_n_in low mid-transaction: immediate return to reset state. The remaining frame is ignored until SCS rises and falls again.

Decomposition:
- Package ad9783_spi_pkg holds:
  - constants INSTR_BITS=8, ADDR_W=5, DATA_W=8, NUM_REGS=32, VERSION_ADDR=5'h1F;
  - FSM state encoding IDLE/INSTR/WDATA/RDATA/DONE;
  - instruction field bit positions.
- One sub-module, spi_sync_edge: a SYNC_STAGES synchronizer plus rise/fall detector, instantiated three times (SCS, SCK, SDI; the SDI instance has its edge outputs unused).

Test Plan:
- Single write: instr 0x05, data 0xA5 at SCK = clk_in/10. Expect wr_strobe_out pulse with addr=5, data=0xA5; reg_data_out(5)=0xA5; busy_out returns to 0 after SCS rise.
- Multi-byte write: instr 0x66 (N=3, addr 6) with data 11,22,33,44. Expect four strobes at addrs 6,5,4,3; a fifth byte before SCS rise produces no strobe.
- Read with wrap: preload 0x00=0x7E and 0x1F=VERSION; instr 0xA0 (read, N=1, addr 0). Expect SDO bytes 0x7E then 0x0A, and oe=1 from instruction end until SCS rise.
- Read-only and mask: write 0xFF to 0x1F. Expect strobe with addr=0x1F, but the register still reads 0x0A.
- Abort: raise SCS after 5 data bits of a write to 0x02. Expect no strobe, reg 0x02 unchanged, FSM in IDLE; a following full write to 0x02 succeeds.
- Reset mid-read: assert rst_n_in during RDATA. Expect spi_sdo_oe_out=0 and all registers 0x00 (0x1F reads VERSION) next cycle; SCK edges are ignored until a new SCS fall.

Source files
------------

// File: rtl/ad9783_spi_pkg.sv
// Shared constants and FSM encoding for the AD9783 serial-port responder.
package ad9783_spi_pkg;

    localparam int INSTR_BITS = 8;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 8;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = $clog2(INSTR_BITS);

    localparam logic [ADDR_W-1:0] VERSION_ADDR = 5'h1F;

    localparam int RNW_BIT = 7;
    localparam int N_HI    = 6;
    localparam int N_LO    = 5;
    localparam int ADDR_HI = 4;
    localparam int ADDR_LO = 0;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        WDATA,
        RDATA,
        DONE
    } state_e;

endpackage

// File: rtl/ad9783_spi_responder_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_in,
    output logic q_out,
    output logic rise_out,
    output logic fall_out
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_in};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign q_out    = sync_q[STAGES-1];
    assign rise_out = sync_q[STAGES-1] & ~dly_q;
    assign fall_out = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/ad9783_spi_responder.sv
// AD9783 serial control port target: 1-4 byte reads/writes into a 32x8 register file.
import ad9783_spi_pkg::*;

module ad9783_spi_responder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [7:0]  VERSION        = 8'h0A,
    parameter logic [31:0] REG_WRITE_MASK = 32'h7FFF_FFFF
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              spi_scs_in,
    input  logic              spi_sck_in,
    input  logic              spi_sdi_in,
    output logic              spi_sdo_out,
    output logic              spi_sdo_oe_out,
    output logic              wr_strobe_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [DATA_W-1:0] wr_data_out,
    input  logic [ADDR_W-1:0] reg_addr_in,
    output logic [DATA_W-1:0] reg_data_out,
    output logic              busy_out
);

    localparam logic [7:0]       SETTLE   = 8'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(INSTR_BITS - 1);

    logic scs_s, scs_rise, scs_fall;
    logic sck_s, sck_rise, sck_fall;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scs (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(spi_scs_in),
        .q_out(scs_s), .rise_out(scs_rise), .fall_out(scs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(spi_sck_in),
        .q_out(sck_s), .rise_out(sck_rise), .fall_out(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(spi_sdi_in),
        .q_out(sdi_s), .rise_out(sdi_rise_unused), .fall_out(sdi_fall_unused)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] sdo_sh_q, sdo_sh_d;
    logic              oe_q, oe_d;
    logic              pend_q, pend_d;
    logic              strobe_q, strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              armed_q, armed_d;
    logic [7:0]        settle_q, settle_d;
    logic              we;
    logic [DATA_W-1:0] sdi_byte;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        return (a == VERSION_ADDR) ? VERSION : regs_q[a];
    endfunction

    assign sdi_byte = {shift_q[DATA_W-2:0], sdi_s};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        sdo_sh_d  = sdo_sh_q;
        oe_d      = oe_q;
        pend_d    = pend_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        armed_d   = armed_q;
        settle_d  = settle_q;
        we        = 1'b0;

        // A frame left running across reset must see SCS high before we respond again
        if (settle_q != SETTLE) settle_d = settle_q + 8'd1;
        if (settle_q == SETTLE && scs_s) armed_d = 1'b1;

        if (pend_q) begin
            pend_d    = 1'b0;
            strobe_d  = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = shift_q;
            we        = REG_WRITE_MASK[addr_q];
            addr_d    = addr_q - 5'd1;
            cnt_d     = cnt_q - 2'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (scs_fall && armed_q) begin
                    state_d   = INSTR;
                    bit_cnt_d = '0;
                end
            end
            INSTR: begin
                if (sck_rise) begin
                    shift_d   = sdi_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        addr_d = sdi_byte[ADDR_HI:ADDR_LO];
                        cnt_d  = sdi_byte[N_HI:N_LO];
                        if (sdi_byte[RNW_BIT]) begin
                            state_d  = RDATA;
                            sdo_sh_d = rd(sdi_byte[ADDR_HI:ADDR_LO]);
                            oe_d     = 1'b1;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
            end
            WDATA: begin
                if (pend_q) begin
                    if (cnt_q == 2'd0) state_d = DONE;
                end else if (sck_rise) begin
                    shift_d   = sdi_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) pend_d = 1'b1;
                end
            end
            RDATA: begin
                // The fall right after a load belongs to the previous bit slot
                if (sck_fall && bit_cnt_q != '0)
                    sdo_sh_d = {sdo_sh_q[DATA_W-2:0], 1'b0};
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        if (cnt_q == 2'd0) begin
                            state_d = DONE;
                        end else begin
                            addr_d   = addr_q - 5'd1;
                            cnt_d    = cnt_q - 2'd1;
                            sdo_sh_d = rd(addr_q - 5'd1);
                        end
                    end
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        if (scs_rise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            sdo_sh_q  <= '0;
            oe_q      <= 1'b0;
            pend_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            armed_q   <= 1'b0;
            settle_q  <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            sdo_sh_q  <= sdo_sh_d;
            oe_q      <= oe_d;
            pend_q    <= pend_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            armed_q   <= armed_d;
            settle_q  <= settle_d;
            if (we) regs_q[addr_q] <= shift_q;
        end
    end

    assign spi_sdo_out    = sdo_sh_q[DATA_W-1] & oe_q;
    assign spi_sdo_oe_out = oe_q;
    assign wr_strobe_out  = strobe_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign reg_data_out   = rd(reg_addr_in);
    assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_ad9783_spi_responder.sv
// Directed and randomized frames against a byte-level model of the register file.
module tb_ad9783_spi_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scs = 1'b1;
    logic       sck = 1'b0;
    logic       sdi = 1'b0;
    logic       sdo, sdo_oe, wr_strobe, busy;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] reg_addr = 5'd0;
    logic [7:0] reg_data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [7:0]  tx [8];
    logic [7:0]  rx [8];
    logic [7:0]  ref_regs [32];
    logic [31:0] mask = 32'h7FFF_FFFF;
    logic [7:0]  version = 8'h0A;
    logic [4:0]  got_a [$];
    logic [7:0]  got_d [$];
    logic [4:0]  exp_a [$];
    logic [7:0]  exp_d [$];
    bit          rd_mode = 0;
    int          oe_bad = 0;

    ad9783_spi_responder dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .spi_scs_in(scs), .spi_sck_in(sck), .spi_sdi_in(sdi),
        .spi_sdo_out(sdo), .spi_sdo_oe_out(sdo_oe),
        .wr_strobe_out(wr_strobe), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
        .reg_addr_in(reg_addr), .reg_data_out(reg_data), .busy_out(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            got_a.push_back(wr_addr);
            got_d.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] mread(input logic [4:0] a);
        return (a == 5'h1F) ? version : ref_regs[a];
    endfunction

    task automatic check_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
        reg_addr = a;
        #1;
        check(tag, reg_data, exp);
    endtask

    task automatic check_strobes(input string tag);
        check({tag, "_count"}, got_a.size(), exp_a.size());
        for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
            check({tag, "_addr"}, got_a[k], exp_a[k]);
            check({tag, "_data"}, got_d[k], exp_d[k]);
        end
        got_a.delete(); got_d.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    // Bytes of a write land at start address, start-1, ... (mod 32), at most N+1 of them
    task automatic model_write(input int nbytes);
        int         n;
        logic [4:0] a;
        n = int'(tx[0][6:5]);
        a = tx[0][4:0];
        for (int k = 0; k <= n && k < nbytes; k++) begin
            exp_a.push_back(a);
            exp_d.push_back(tx[k+1]);
            if (mask[a]) ref_regs[a] = tx[k+1];
            a = a - 5'd1;
        end
    endtask

    task automatic check_read(input string tag);
        int         n;
        logic [4:0] a;
        n = int'(tx[0][6:5]);
        a = tx[0][4:0];
        for (int k = 0; k <= n; k++) begin
            check(tag, rx[k+1], mread(a));
            a = a - 5'd1;
        end
        check({tag, "_oe"}, oe_bad, 0);
    endtask

    task automatic send_bits(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sdi = tx[i/8][7 - (i % 8)];
            wait_clk(5);
            rx[i/8][7 - (i % 8)] = sdo;
            if (rd_mode && i >= 8 && sdo_oe !== 1'b1) oe_bad++;
            sck = 1'b1;
            wait_clk(5);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        oe_bad = 0;
        scs = 1'b0;
        wait_clk(5);
        check("busy_in_frame", busy, 1'b1);
    endtask

    task automatic cs_high();
        wait_clk(5);
        scs = 1'b1;
        wait_clk(8);
        check("oe_after_scs", sdo_oe, 1'b0);
        check("busy_after_scs", busy, 1'b0);
    endtask

    task automatic xfer(input int nbits);
        rd_mode = tx[0][7];
        cs_low();
        send_bits(nbits);
        cs_high();
        rd_mode = 0;
    endtask

    initial begin
        foreach (ref_regs[i]) ref_regs[i] = 8'h00;
        wait_clk(3);
        check("rst_sdo", sdo, 1'b0);
        check("rst_oe", sdo_oe, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 5'd0);
        check("rst_wr_data", wr_data, 8'd0);
        check("rst_busy", busy, 1'b0);
        check_reg("rst_reg00", 5'h00, 8'h00);
        check_reg("rst_reg1f", 5'h1F, 8'h0A);
        rst_n = 1'b1;
        wait_clk(10);

        // Single-byte write
        tx[0] = 8'h05; tx[1] = 8'hA5;
        xfer(16);
        model_write(1);
        check_strobes("single_wr");
        check_reg("single_wr_reg", 5'h05, 8'hA5);

        // Four-byte write with a fifth byte that must be ignored
        tx[0] = 8'h66; tx[1] = 8'h11; tx[2] = 8'h22;
        tx[3] = 8'h33; tx[4] = 8'h44; tx[5] = 8'h55;
        xfer(48);
        model_write(5);
        check_strobes("multi_wr");
        check_reg("multi_wr_reg3", 5'h03, 8'h44);
        check_reg("multi_wr_reg2", 5'h02, 8'h00);

        // Read across the 0x00 -> 0x1F wrap
        tx[0] = 8'h00; tx[1] = 8'h7E;
        xfer(16);
        model_write(1);
        check_strobes("preload");
        tx[0] = 8'hA0;
        xfer(24);
        check_read("wrap_rd");
        check("wrap_rd_b0", rx[1], 8'h7E);
        check("wrap_rd_b1", rx[2], 8'h0A);
        check_strobes("wrap_rd_nowr");

        // Write to the read-only version address
        tx[0] = 8'h1F; tx[1] = 8'hFF;
        xfer(16);
        model_write(1);
        check_strobes("ro_wr");
        check_reg("ro_reg", 5'h1F, 8'h0A);

        // Abort after five data bits, then a full write
        tx[0] = 8'h02; tx[1] = 8'hC3;
        xfer(13);
        model_write(0);
        check_strobes("abort");
        check_reg("abort_reg", 5'h02, mread(5'h02));
        tx[0] = 8'h02; tx[1] = 8'h3C;
        xfer(16);
        model_write(1);
        check_strobes("after_abort");
        check_reg("after_abort_reg", 5'h02, 8'h3C);

        // Randomized frames
        for (int t = 0; t < 10; t++) begin
            tx[0] = 8'($urandom);
            for (int k = 1; k < 5; k++) tx[k] = 8'($urandom);
            xfer(8 * (int'(tx[0][6:5]) + 2));
            if (tx[0][7]) begin
                check_read("rand_rd");
            end else begin
                model_write(int'(tx[0][6:5]) + 1);
                check_reg("rand_wr_reg", tx[0][4:0], mread(tx[0][4:0]));
            end
            check_strobes("rand");
        end

        // Reset in the middle of a read
        tx[0] = 8'hA5;
        rd_mode = 1;
        cs_low();
        send_bits(11);
        rd_mode = 0;
        check("pre_rst_oe", sdo_oe, 1'b1);
        rst_n = 1'b0;
        wait_clk(1);
        check("midrst_oe", sdo_oe, 1'b0);
        check("midrst_sdo", sdo, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        foreach (ref_regs[i]) ref_regs[i] = 8'h00;
        for (int a = 0; a < 32; a++) check_reg("midrst_reg", 5'(a), mread(5'(a)));
        got_a.delete(); got_d.delete();
        tx[0] = 8'h07; tx[1] = 8'h99;
        send_bits(16);
        check("post_rst_busy", busy, 1'b0);
        check_strobes("post_rst_ignored");
        check_reg("post_rst_reg7", 5'h07, 8'h00);
        cs_high();
        wait_clk(5);
        xfer(16);
        model_write(1);
        check_strobes("post_rst_wr");
        check_reg("post_rst_wr_reg", 5'h07, 8'h99);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
